// File: rtl/bridge_wr_demux_pkg.sv
// Shared definitions for the bridge write demux and the read-side mux select:
// FSM encoding, default target address map and small helpers.
package bridge_wr_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NUM_TGT = 4;

  // Target map: DM, timer0, timer1, UART
  localparam logic [31:0] BASE_DM   = 32'h0000_0000;
  localparam logic [31:0] BASE_TMR0 = 32'h0000_7F00;
  localparam logic [31:0] BASE_TMR1 = 32'h0000_7F10;
  localparam logic [31:0] BASE_UART = 32'h0000_7F20;
  localparam logic [31:0] MASK_DM   = 32'hFFFF_E000;
  localparam logic [31:0] MASK_TMR0 = 32'hFFFF_FFF0;
  localparam logic [31:0] MASK_TMR1 = 32'hFFFF_FFF0;
  localparam logic [31:0] MASK_UART = 32'hFFFF_FFF0;

  function automatic logic [NUM_TGT-1:0] tgt_onehot(input logic [1:0] sel);
    logic [NUM_TGT-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bridge_wr_demux_addr_decode.sv
// Combinational 4-target address decoder; lowest matching index wins.
// The read path instantiates the same module so both paths share one map.
module addr_decode_4
  import bridge_wr_demux_pkg::*;
#(
  parameter int            AW    = 32,
  parameter logic [AW-1:0] BASE0 = AW'(BASE_DM),
  parameter logic [AW-1:0] BASE1 = AW'(BASE_TMR0),
  parameter logic [AW-1:0] BASE2 = AW'(BASE_TMR1),
  parameter logic [AW-1:0] BASE3 = AW'(BASE_UART),
  parameter logic [AW-1:0] MASK0 = AW'(MASK_DM),
  parameter logic [AW-1:0] MASK1 = AW'(MASK_TMR0),
  parameter logic [AW-1:0] MASK2 = AW'(MASK_TMR1),
  parameter logic [AW-1:0] MASK3 = AW'(MASK_UART)
) (
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [1:0]    sel
);

  localparam logic [NUM_TGT-1:0][AW-1:0] BASE = {BASE3, BASE2, BASE1, BASE0};
  localparam logic [NUM_TGT-1:0][AW-1:0] MASK = {MASK3, MASK2, MASK1, MASK0};

  logic [NUM_TGT-1:0] match;

  for (genvar i = 0; i < NUM_TGT; i++) begin : g_match
    assign match[i] = (addr & MASK[i]) == BASE[i];
  end

  // Scan high to low so the lowest matching index is the last one written
  always_comb begin
    hit = |match;
    sel = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if (match[i]) sel = 2'(i);
    end
  end

endmodule

// File: rtl/bridge_wr_demux.sv
// CPU store -> one-of-4 peripheral write demux with per-target req/ack
// handshake, address-miss and timeout error reporting.
module bridge_wr_demux
  import bridge_wr_demux_pkg::*;
#(
  parameter int            AW      = 32,
  parameter int            DW      = 32,
  parameter logic [AW-1:0] BASE0   = AW'(BASE_DM),
  parameter logic [AW-1:0] BASE1   = AW'(BASE_TMR0),
  parameter logic [AW-1:0] BASE2   = AW'(BASE_TMR1),
  parameter logic [AW-1:0] BASE3   = AW'(BASE_UART),
  parameter logic [AW-1:0] MASK0   = AW'(MASK_DM),
  parameter logic [AW-1:0] MASK1   = AW'(MASK_TMR0),
  parameter logic [AW-1:0] MASK2   = AW'(MASK_TMR1),
  parameter logic [AW-1:0] MASK3   = AW'(MASK_UART),
  parameter int            TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [3:0]    cpu_be,
  output logic          cpu_stall,
  output logic          cpu_err,
  output logic [3:0]    dev_we,
  output logic [AW-1:0] dev_addr,
  output logic [DW-1:0] dev_wdata,
  output logic [3:0]    dev_be,
  input  logic [3:0]    dev_ack,
  output logic [7:0]    err_cnt
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, state_nx;
  logic            err_q, err_nx;
  logic [1:0]      sel_q;
  logic [CW-1:0]   tcnt;
  logic            dec_hit;
  logic [1:0]      dec_sel;
  logic            accept;
  logic            acked;
  logic            tmo;

  addr_decode_4 #(
    .AW(AW),
    .BASE0(BASE0), .BASE1(BASE1), .BASE2(BASE2), .BASE3(BASE3),
    .MASK0(MASK0), .MASK1(MASK1), .MASK2(MASK2), .MASK3(MASK3)
  ) u_dec (
    .addr(cpu_addr),
    .hit (dec_hit),
    .sel (dec_sel)
  );

  assign accept = (state == ST_IDLE) && cpu_we;
  assign acked  = dev_ack[sel_q];
  assign tmo    = tcnt == CW'(TIMEOUT - 1);

  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    case (state)
      ST_IDLE: begin
        if (cpu_we) begin
          state_nx = dec_hit ? ST_REQ : ST_DONE;
          err_nx   = ~dec_hit;
        end
      end
      ST_REQ: begin
        // Ack takes precedence over a timeout landing in the same cycle
        if (acked) begin
          state_nx = ST_DONE;
          err_nx   = 1'b0;
        end else if (tmo) begin
          state_nx = ST_DONE;
          err_nx   = 1'b1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
    end
  end

  // Request latches only move on an IDLE accept, so they hold through REQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      dev_addr  <= '0;
      dev_wdata <= '0;
      dev_be    <= '0;
    end else if (accept) begin
      sel_q     <= dec_sel;
      dev_addr  <= cpu_addr;
      dev_wdata <= cpu_wdata;
      dev_be    <= cpu_be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= '0;
    else        tcnt <= (state == ST_REQ) ? tcnt + CW'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if ((state == ST_DONE) && err_q && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end

  // Strobes decode straight from state so an async reset drops them at once
  assign dev_we    = (state == ST_REQ) ? tgt_onehot(sel_q) : 4'b0000;
  assign cpu_stall = cpu_we & (state != ST_DONE);
  assign cpu_err   = (state == ST_DONE) & err_q;

endmodule

// File: tb/tb_bridge_wr_demux.sv
// Scoreboard bench for bridge_wr_demux: stores push expectations, the monitor
// pops and compares when the CPU is released, and also plays the targets' acks.
module tb_bridge_wr_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_stall;
  logic        cpu_err;
  logic [3:0]  dev_we;
  logic [31:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [3:0]  dev_be;
  logic [3:0]  dev_ack;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  bridge_wr_demux #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_be(dev_be),
    .dev_ack(dev_ack), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [3:0]  we;
    int          we_cyc;
    int          stall_cyc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   exp_ec = 0;
  int   done_cnt = 0;

  // Target behaviour for the store in flight
  int         ack_dly = -1;
  logic [3:0] ack_bit = 4'b0;
  logic [3:0] spur = 4'b0;

  // Monitor state
  int          we_cyc, stall_cyc;
  logic [3:0]  we_or;
  logic [31:0] a0, d0;
  logic [3:0]  b0;
  logic        unstable;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      we_cyc = 0; stall_cyc = 0; we_or = 4'b0; unstable = 1'b0; dev_ack = 4'b0;
    end else begin
      if (dev_we != 4'b0) begin
        we_cyc++;
        we_or |= dev_we;
        if (we_cyc == 1) begin
          a0 = dev_addr; d0 = dev_wdata; b0 = dev_be;
        end else if (dev_addr !== a0 || dev_wdata !== d0 || dev_be !== b0) begin
          unstable = 1'b1;
        end
      end
      if (cpu_we && cpu_stall) stall_cyc++;
      if (cpu_we && !cpu_stall) begin
        if (sbq.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("cpu_err",   32'(cpu_err),  32'(e.err));
          chk("dev_we",    32'(we_or),    32'(e.we));
          chk("we_cycles", we_cyc,        e.we_cyc);
          chk("stall_cyc", stall_cyc,     e.stall_cyc);
          chk("dev_addr",  dev_addr,      e.addr);
          chk("dev_wdata", dev_wdata,     e.wdata);
          chk("dev_be",    32'(dev_be),   32'(e.be));
          chk("stable",    32'(unstable), 32'd0);
        end
        we_cyc = 0; stall_cyc = 0; we_or = 4'b0; unstable = 1'b0;
        done_cnt++;
      end
      dev_ack = (dev_we != 4'b0) ?
                (((ack_dly >= 0 && we_cyc > ack_dly) ? ack_bit : 4'b0) | spur) : 4'b0;
    end
  end

  // Called at posedge+1; tgt<0 means the address must miss, dly<0 means never ack
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input int tgt, input int dly, input logic [3:0] sp);
    exp_t x;
    int   t0;
    bit   ok;
    x.addr = a; x.wdata = d; x.be = be;
    if (tgt < 0) begin
      x.we = 4'b0; x.we_cyc = 0; x.err = 1'b1;
    end else begin
      x.we = 4'(1 << tgt);
      if (dly < 0 || dly >= 16) begin x.we_cyc = 16; x.err = 1'b1; end
      else begin x.we_cyc = dly + 1; x.err = 1'b0; end
    end
    x.stall_cyc = 1 + x.we_cyc;
    sbq.push_back(x);
    ack_dly = dly; ack_bit = x.we; spur = sp;
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_be = be;
    t0 = done_cnt; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (done_cnt != t0) ok = 1'b1;
    end
    if (!ok) chk("store_timeout", 32'd0, 32'd1);
    if (x.err && exp_ec != 255) exp_ec++;
    chk("err_cnt", 32'(err_cnt), exp_ec);
  endtask

  task automatic idle(input int n);
    cpu_we = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 1'b0; cpu_we = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_be = 4'h0;
    #12;
    chk("rst_dev_we",   32'(dev_we),    32'd0);
    chk("rst_cpu_err",  32'(cpu_err),   32'd0);
    chk("rst_err_cnt",  32'(err_cnt),   32'd0);
    chk("rst_dev_addr", dev_addr,       32'd0);
    chk("rst_wdata",    dev_wdata,      32'd0);
    chk("rst_stall",    32'(cpu_stall), 32'd1);
    cpu_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    store(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 4'b0);   idle(1);
    store(32'h0000_7F04, 32'h1122_3344, 4'h3, 1, 5, 4'b0);   idle(1);
    store(32'h0000_7F14, 32'h5566_7788, 4'hC, 2, 2, 4'b0);
    store(32'h0000_9000, 32'h0000_CAFE, 4'hF, -1, 0, 4'b0);  idle(1);
    store(32'h0000_7F20, 32'hA5A5_A5A5, 4'h1, 3, -1, 4'b0);  idle(1);
    store(32'h0000_7F2C, 32'h0BAD_F00D, 4'h2, 3, 15, 4'b0);  idle(1);
    store(32'h0000_1FFC, 32'h1357_9BDF, 4'h8, 0, 1, 4'b0);

    // Reset in the middle of a REQ to timer1
    cpu_we = 1'b1; cpu_addr = 32'h0000_7F18; cpu_wdata = 32'h7777_0000; cpu_be = 4'hF;
    ack_dly = -1; ack_bit = 4'b0100; spur = 4'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_we", 32'(dev_we), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we",      32'(dev_we),  32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_cpu_err", 32'(cpu_err), 32'd0);
    exp_ec = 0;
    cpu_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    store(32'h0000_7F18, 32'h7777_1111, 4'hF, 2, 1, 4'b0);  idle(1);

    // Back-to-back, spurious ack on target 0 while target 2 is requested
    store(32'h0000_0100, 32'h0000_0001, 4'hF, 0, 0, 4'b0);
    store(32'h0000_7F10, 32'h0000_0002, 4'hF, 2, 3, 4'b0001); idle(1);

    // Drive err_cnt into saturation with misses
    for (int i = 0; i < 258; i++) store(32'h0001_0000 + 32'(i), 32'(i), 4'hF, -1, 0, 4'b0);
    idle(2);
    chk("err_cnt_sat", 32'(err_cnt), 32'hFF);
    chk("sb_drained",  sbq.size(),   0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
